// File: rtl/fifo_write_controller_if.sv
// rtl/fifo_write_controller_if.sv - write-side FIFO handshake and status bundle
interface fifo_write_controller_if #(
  parameter int depth = 8
);
  logic             write;
  logic [depth-1:0] rd_gray_value;
  logic             wr_en;
  logic [depth-2:0] wr_address;
  logic [depth-1:0] gray_value;
  logic             full;
  logic             almost_full;
  logic [depth-1:0] level;
  logic             overflow;

  modport master (
    output write, rd_gray_value,
    input  wr_en, wr_address, gray_value, full, almost_full, level, overflow
  );

  modport slave (
    input  write, rd_gray_value,
    output wr_en, wr_address, gray_value, full, almost_full, level, overflow
  );
endinterface

// File: rtl/fifo_write_controller.sv
// rtl/fifo_write_controller.sv - dual-clock FIFO write pointer/status controller
// Optional sticky overflow flag enabled by defining FIFO_WR_OVERFLOW_EN.
module fifo_write_controller #(
  parameter int depth              = 8,
  parameter int almost_full_margin = 2
) (
  input logic                   wr_clock,
  input logic                   reset_n,
  fifo_write_controller_if.slave bus
);

  localparam logic [depth-1:0] capacity     = {1'b1, {(depth-1){1'b0}}};
  localparam logic [depth-1:0] af_threshold = capacity - depth'(almost_full_margin);

  logic [depth-1:0] wr_ptr;
  logic [depth-1:0] next_ptr;
  logic [depth-1:0] next_level;
  logic [depth-1:0] sync1;
  logic [depth-1:0] sync2;
  logic [depth-1:0] rd_bin;
  logic [depth-1:0] gray_q;
  logic [depth-1:0] level_q;
  logic             full_q;
  logic             almost_full_q;

  assign bus.wr_en       = bus.write & ~full_q & reset_n;
  assign next_ptr        = wr_ptr + {{(depth-1){1'b0}}, bus.wr_en};
  assign next_level      = next_ptr - rd_bin;
  assign bus.wr_address  = wr_ptr[depth-2:0];
  assign bus.gray_value  = gray_q;
  assign bus.level       = level_q;
  assign bus.full        = full_q;
  assign bus.almost_full = almost_full_q;

  // Each binary bit is the XOR of all gray bits at and above it.
  always_comb begin
    rd_bin = '0;
    for (int i = 0; i < depth; i++) begin
      rd_bin[i] = ^(sync2 >> i);
    end
  end

  always_ff @(posedge wr_clock) begin
    if (!reset_n) begin
      wr_ptr        <= '0;
      sync1         <= '0;
      sync2         <= '0;
      gray_q        <= '0;
      level_q       <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
    end else begin
      sync1         <= bus.rd_gray_value;
      sync2         <= sync1;
      wr_ptr        <= next_ptr;
      gray_q        <= next_ptr ^ (next_ptr >> 1);
      level_q       <= next_level;
      full_q        <= (next_ptr[depth-1] != rd_bin[depth-1]) &&
                       (next_ptr[depth-2:0] == rd_bin[depth-2:0]);
      almost_full_q <= (next_level >= af_threshold);
    end
  end

`ifdef FIFO_WR_OVERFLOW_EN
  logic overflow_q;

  always_ff @(posedge wr_clock) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else if (bus.write && full_q) begin
      overflow_q <= 1'b1;
    end
  end

  assign bus.overflow = overflow_q;
`else
  assign bus.overflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_write_controller.sv
// tb/tb_fifo_write_controller.sv - directed self-checking bench, depth=4 margin=2
module tb_fifo_write_controller;

  logic clk = 1'b0;
  logic reset_n;
  int   passed = 0;
  int   total  = 0;

`ifdef FIFO_WR_OVERFLOW_EN
  localparam bit ovf_en = 1'b1;
`else
  localparam bit ovf_en = 1'b0;
`endif

  always #5 clk = ~clk;

  fifo_write_controller_if #(.depth(4)) bus ();

  fifo_write_controller #(
    .depth              (4),
    .almost_full_margin (2)
  ) dut (
    .wr_clock (clk),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  function automatic logic [3:0] to_gray(int v);
    logic [3:0] b;
    b = 4'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.write = 1'b0;
    bus.rd_gray_value = 4'd0;
    tick();
    tick();
    total++; if (bus.level !== 4'd0) $display("FAIL reset_level got %0d want 0", bus.level); else passed++;
    total++; if (bus.full !== 1'b0) $display("FAIL reset_full got %0b want 0", bus.full); else passed++;
    total++; if (bus.almost_full !== 1'b0) $display("FAIL reset_af got %0b want 0", bus.almost_full); else passed++;
    total++; if (bus.gray_value !== 4'd0) $display("FAIL reset_gray got %0h want 0", bus.gray_value); else passed++;
    total++; if (bus.wr_address !== 3'd0) $display("FAIL reset_addr got %0d want 0", bus.wr_address); else passed++;
    total++; if (bus.overflow !== 1'b0) $display("FAIL reset_ovf got %0b want 0", bus.overflow); else passed++;
    bus.write = 1'b1;
    #1;
    total++; if (bus.wr_en !== 1'b0) $display("FAIL reset_wr_en got %0b want 0", bus.wr_en); else passed++;
    bus.write = 1'b0;
  endtask

  task automatic test_fill();
    logic [3:0] gtab [9] = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12, 4'd12};
    reset_n = 1'b1;
    bus.write = 1'b1;
    for (int k = 0; k < 9; k++) begin
      #1;
      total++; if (bus.wr_en !== (k < 8)) $display("FAIL fill_wr_en[%0d] got %0b want %0b", k, bus.wr_en, (k < 8)); else passed++;
      total++; if (bus.wr_address !== 3'(k)) $display("FAIL fill_addr[%0d] got %0d want %0d", k, bus.wr_address, 3'(k)); else passed++;
      tick();
      total++; if (bus.gray_value !== gtab[k]) $display("FAIL fill_gray[%0d] got %0d want %0d", k, bus.gray_value, gtab[k]); else passed++;
      total++; if (bus.level !== 4'((k < 8) ? k + 1 : 8)) $display("FAIL fill_level[%0d] got %0d want %0d", k, bus.level, (k < 8) ? k + 1 : 8); else passed++;
      total++; if (bus.full !== (k >= 7)) $display("FAIL fill_full[%0d] got %0b want %0b", k, bus.full, (k >= 7)); else passed++;
      total++; if (bus.almost_full !== (k >= 5)) $display("FAIL fill_af[%0d] got %0b want %0b", k, bus.almost_full, (k >= 5)); else passed++;
      total++; if (bus.overflow !== (ovf_en && k == 8)) $display("FAIL fill_ovf[%0d] got %0b want %0b", k, bus.overflow, (ovf_en && k == 8)); else passed++;
    end
    bus.write = 1'b0;
  endtask

  task automatic test_read_release();
    bus.rd_gray_value = 4'b0010;
    for (int e = 1; e <= 4; e++) begin
      tick();
      total++; if (bus.full !== (e < 3)) $display("FAIL rel_full[edge %0d] got %0b want %0b", e, bus.full, (e < 3)); else passed++;
      total++; if (bus.level !== ((e < 3) ? 4'd8 : 4'd5)) $display("FAIL rel_level[edge %0d] got %0d want %0d", e, bus.level, (e < 3) ? 8 : 5); else passed++;
      total++; if (bus.almost_full !== (e < 3)) $display("FAIL rel_af[edge %0d] got %0b want %0b", e, bus.almost_full, (e < 3)); else passed++;
      total++; if (bus.overflow !== ovf_en) $display("FAIL rel_ovf[edge %0d] got %0b want %0b", e, bus.overflow, ovf_en); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    bus.write = 1'b1;
    reset_n = 1'b0;
    bus.rd_gray_value = 4'd0;
    #1;
    total++; if (bus.wr_en !== 1'b0) $display("FAIL mid_wr_en got %0b want 0", bus.wr_en); else passed++;
    tick();
    total++; if (bus.level !== 4'd0) $display("FAIL mid_level got %0d want 0", bus.level); else passed++;
    total++; if (bus.full !== 1'b0) $display("FAIL mid_full got %0b want 0", bus.full); else passed++;
    total++; if (bus.gray_value !== 4'd0) $display("FAIL mid_gray got %0h want 0", bus.gray_value); else passed++;
    total++; if (bus.wr_address !== 3'd0) $display("FAIL mid_addr got %0d want 0", bus.wr_address); else passed++;
    total++; if (bus.overflow !== 1'b0) $display("FAIL mid_ovf got %0b want 0", bus.overflow); else passed++;
    reset_n = 1'b1;
    bus.write = 1'b0;
  endtask

  task automatic test_wrap();
    int wp = 0;
    logic [3:0] prev_gray;
    prev_gray = bus.gray_value;
    for (int i = 0; i < 40; i++) begin
      bus.write = 1'b1;
      bus.rd_gray_value = to_gray(wp);
      tick();
      wp++;
      total++; if ($countones(bus.gray_value ^ prev_gray) != 1) $display("FAIL wrap_onebit[%0d] got %0h prev %0h want one bit change", i, bus.gray_value, prev_gray); else passed++;
      total++; if (bus.gray_value !== to_gray(wp)) $display("FAIL wrap_gray[%0d] got %0h want %0h", i, bus.gray_value, to_gray(wp)); else passed++;
      total++; if (bus.level !== 4'd1) $display("FAIL wrap_level_w[%0d] got %0d want 1", i, bus.level); else passed++;
      total++; if (bus.full !== 1'b0) $display("FAIL wrap_full[%0d] got %0b want 0", i, bus.full); else passed++;
      prev_gray = bus.gray_value;
      bus.write = 1'b0;
      for (int j = 0; j < 3; j++) begin
        bus.rd_gray_value = to_gray(wp);
        tick();
        total++; if (bus.level !== ((j < 2) ? 4'd1 : 4'd0)) $display("FAIL wrap_level_i[%0d.%0d] got %0d want %0d", i, j, bus.level, (j < 2) ? 1 : 0); else passed++;
      end
    end
    total++; if (bus.wr_address !== 3'd0) $display("FAIL wrap_addr got %0d want 0", bus.wr_address); else passed++;
    total++; if (bus.gray_value !== 4'b1100) $display("FAIL wrap_final_gray got %0h want c", bus.gray_value); else passed++;
    total++; if (bus.overflow !== 1'b0) $display("FAIL wrap_ovf got %0b want 0", bus.overflow); else passed++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_read_release();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fifo_write_controller.md
Name: fifo_write_controller

Overview:
Write-side pointer and status controller of the dual-clock FIFO, the counterpart stage that consumes the gray-coded read pointer produced on the read side. It resynchronises the incoming read gray pointer into the write clock domain, keeps the binary write pointer, and produces RAM write address/enable. It also produces full, almost_full and fill level, plus its own gray-coded write pointer for the read side. Single clock domain (wr_clock); the read pointer input is asynchronous to it.

Parameters:
depth, 8, pointer width in bits including wrap bit; FIFO capacity = 2^(depth-1) entries; minimum 2
almost_full_margin, 2, almost_full asserts when free entries <= this value; range 0..2^(depth-1)-1

Ports:
wr_clock  input  1  write-domain clock, all logic on rising edge
reset_n  input  1  synchronous, active-low reset (sampled on rising edge of wr_clock)
write  input  1  write request from producer
rd_gray_value  input  depth  gray-coded read pointer from read domain, asynchronous
wr_en  output  1  RAM write enable = write & ~full & reset_n (combinational)
wr_address  output  depth-1  RAM write address = wr_ptr[depth-2:0]
gray_value  output  depth  registered gray-coded write pointer, to read domain
full  output  1  registered, FIFO full as seen from write domain
almost_full  output  1  registered, level >= capacity - almost_full_margin
level  output  depth  registered fill count, 0..capacity
overflow  output  1  sticky overflow flag (see Optional Feature)

Behaviour:
- Reset (reset_n low at a rising edge): wr_ptr, sync1, sync2, gray_value, level, full, almost_full, overflow all <= 0. wr_en held 0 while reset_n low. Reset mid-operation discards all state; no partial write occurs in the reset cycle.
- Synchroniser: sync1 <= rd_gray_value; sync2 <= sync1. No logic between the stages. sync2 is the only consumer of rd_gray_value.
- Gray-to-binary: rd_bin[i] = XOR of sync2[depth-1:i]. Combinational, from sync2 only.
- Pointer: next_ptr = wr_ptr + wr_en, modulo 2^depth. wr_ptr <= next_ptr. Wrap from all-ones to 0 is natural.
- gray_value <= next_ptr ^ (next_ptr >> 1). It is registered so it changes exactly one bit per increment and is glitch-free for the read side.
- level <= (next_ptr - rd_bin) mod 2^depth.
- full <= (next_ptr[depth-1] != rd_bin[depth-1]) && (next_ptr[depth-2:0] == rd_bin[depth-2:0]). This is equivalent to the next level equalling capacity.
- almost_full <= next level >= capacity - almost_full_margin.
- Latency: a write updates wr_address, gray_value, level and full on the same edge. A change on rd_gray_value reaches level, full and almost_full on the 3rd rising edge after it is stable (2 synchroniser edges + 1 status edge).
- Pessimism: status lags reads by 3 cycles. full may stay high after space frees; it never deasserts early. level never under-reports occupancy.
- Write while full: wr_en = 0; wr_ptr, gray_value and level are unchanged; data is dropped.
- Simultaneous write and read-pointer advance in the same cycle: both apply. level = next_ptr - rd_bin, evaluated with the synchronised read pointer.
- level never exceeds capacity, provided rd_gray_value is a legal gray pointer that never passes the write pointer.

Optional Feature:
FIFO_WR_OVERFLOW_EN
- Defined: overflow <= 1 on any rising edge where reset_n = 1, write = 1 and full = 1. It stays high until reset.
- Not defined: the overflow port remains and is tied to 0; no extra register is built.

Test Plan:
- depth=4 (capacity 8), rd_gray_value=0, reset then 9 consecutive writes -> wr_address 0..7 and wr_en high for 8 cycles. full=1 and level=8 after the 8th edge. 9th write: wr_en=0, wr_ptr unchanged. gray_value sequence 1,3,2,6,7,5,4,12.
- From full, drive rd_gray_value=4'b0010 (binary 3) -> full=0, level=5 exactly on the 3rd edge, not earlier.
- Wrap: alternate writes with rd_gray_value tracking the write pointer for 40 writes -> wr_ptr wraps 15 to 0. gray_value changes exactly one bit per write. level stays in 0..1. full is never asserted.
- almost_full_margin=2 with rd pointer fixed at 0 -> almost_full rises on the edge where level becomes 6 and falls once the synchronised read pointer brings level below 6.
- Assert reset_n low for 1 cycle while level=5 and write=1 -> wr_en=0 in that cycle. Next cycle: level=0, full=0, gray_value=0, wr_address=0.
- FIFO_WR_OVERFLOW_EN defined: 9th write of the first scenario -> overflow=1 from the next edge, held through later reads until reset. Macro undefined: overflow stays 0.
